// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak round scheduler.
package keccak_pkg;

    localparam int NUM_ROUNDS_DEFAULT = 24;
    localparam int IDX_W_DEFAULT      = 5;
    localparam int Z_WIDTH            = 64;

    typedef logic [IDX_W_DEFAULT-1:0] round_idx_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ABSORB  = 2'd1,
        S_ROUND   = 2'd2,
        S_SQUEEZE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/keccak_round_counter.sv
// Round counter: steps through 0..NUM_ROUNDS-1 and wraps to 0 after the last round.
// Optional UNROLL2_EN: two rounds per cycle, stepping by 2, with idx_b = idx + 1.
module keccak_round_counter #(
    parameter int NUM_ROUNDS = 24,
    parameter int IDX_W      = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_b,
    output logic             last
);

`ifdef UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic [IDX_W-1:0] cnt_q;

    assign last = (cnt_q == IDX_W'(NUM_ROUNDS - STEP));
    assign idx  = cnt_q;

`ifdef UNROLL2_EN
    assign idx_b = cnt_q + IDX_W'(1);
`else
    assign idx_b = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= last ? '0 : cnt_q + IDX_W'(STEP);
        end
    end

endmodule

// File: rtl/keccak_round_scheduler.sv
// Keccak absorb/permute/squeeze control FSM driving an external state datapath.
// Optional UNROLL2_EN (handled in keccak_round_counter): two rounds per ROUND cycle.
module keccak_round_scheduler
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
    parameter int IDX_W      = IDX_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             BLK_VALID,
    input  logic             BLK_LAST,
    output logic             BLK_READY,
    output logic             STATE_LOAD,
    output logic             STATE_CLEAR,
    output logic             ROUND_EN,
    output logic [IDX_W-1:0] ROUND_IDX,
    output logic [IDX_W-1:0] ROUND_IDX_B,
    output logic             DIGEST_VALID,
    input  logic             DIGEST_ACK,
    output logic             WAIT_FOR_NEW_MESSAGE
);

    sched_state_t     state_q, state_d;
    logic             last_q, last_d;
    logic             wfnm_q, wfnm_d;
    logic             rst_clr_q;
    logic             ack_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [IDX_W-1:0] cnt_idx;
    logic [IDX_W-1:0] cnt_idx_b;

    assign cnt_en = (state_q == S_ROUND) && CE;

    keccak_round_counter #(
        .NUM_ROUNDS (NUM_ROUNDS),
        .IDX_W      (IDX_W)
    ) u_round_counter (
        .CLK   (CLK),
        .RST   (RST),
        .en    (cnt_en),
        .idx   (cnt_idx),
        .idx_b (cnt_idx_b),
        .last  (cnt_last)
    );

    always_ff @(posedge CLK) begin
        // clear stays up for one extra cycle after reset is released
        rst_clr_q <= RST;
        if (RST) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            wfnm_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wfnm_q  <= wfnm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wfnm_d     = wfnm_q;
        BLK_READY  = 1'b0;
        STATE_LOAD = 1'b0;
        ROUND_EN   = 1'b0;
        ack_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                BLK_READY = CE;
                if (CE && BLK_VALID) begin
                    last_d  = BLK_LAST;
                    wfnm_d  = 1'b0;
                    state_d = S_ABSORB;
                end
            end
            S_ABSORB: begin
                STATE_LOAD = CE;
                if (CE) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                ROUND_EN = CE;
                if (CE && cnt_last) begin
                    state_d = last_q ? S_SQUEEZE : S_IDLE;
                end
            end
            S_SQUEEZE: begin
                if (CE && DIGEST_ACK) begin
                    ack_clr = 1'b1;
                    wfnm_d  = 1'b1;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ROUND_IDX            = (state_q == S_ROUND) ? cnt_idx : '0;
    assign ROUND_IDX_B          = (state_q == S_ROUND) ? cnt_idx_b : '0;
    assign DIGEST_VALID         = (state_q == S_SQUEEZE);
    assign WAIT_FOR_NEW_MESSAGE = wfnm_q && (state_q == S_IDLE);
    assign STATE_CLEAR          = RST || rst_clr_q || ack_clr;

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// Self-checking bench for keccak_round_scheduler: directed scenarios plus a randomized run.
module tb_keccak_round_scheduler;

`ifdef UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int NR = 24 / STEP;

    logic       CLK = 1'b0;
    logic       RST, CE, BLK_VALID, BLK_LAST, DIGEST_ACK;
    logic       BLK_READY, STATE_LOAD, STATE_CLEAR, ROUND_EN, DIGEST_VALID, WAIT_FOR_NEW_MESSAGE;
    logic [4:0] ROUND_IDX, ROUND_IDX_B;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    keccak_round_scheduler #(.NUM_ROUNDS(24), .IDX_W(5)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .BLK_VALID(BLK_VALID), .BLK_LAST(BLK_LAST),
        .BLK_READY(BLK_READY), .STATE_LOAD(STATE_LOAD), .STATE_CLEAR(STATE_CLEAR),
        .ROUND_EN(ROUND_EN), .ROUND_IDX(ROUND_IDX), .ROUND_IDX_B(ROUND_IDX_B),
        .DIGEST_VALID(DIGEST_VALID), .DIGEST_ACK(DIGEST_ACK),
        .WAIT_FOR_NEW_MESSAGE(WAIT_FOR_NEW_MESSAGE)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1; CE = 1; BLK_VALID = 0; BLK_LAST = 0; DIGEST_ACK = 0;
        step(); step();
        #1;
        checks++; if (STATE_CLEAR !== 1'b1) begin failures++; $display("FAIL reset_clear got=%b exp=1", STATE_CLEAR); end
        checks++; if (BLK_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", BLK_READY); end
        checks++; if ({STATE_LOAD, ROUND_EN, DIGEST_VALID} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {STATE_LOAD, ROUND_EN, DIGEST_VALID}); end
        checks++; if ({ROUND_IDX, ROUND_IDX_B} !== 10'd0) begin failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", ROUND_IDX, ROUND_IDX_B); end
        checks++; if (WAIT_FOR_NEW_MESSAGE !== 1'b1) begin failures++; $display("FAIL reset_wait got=%b exp=1", WAIT_FOR_NEW_MESSAGE); end
        CE = 0; #1;
        checks++; if (BLK_READY !== 1'b0) begin failures++; $display("FAIL reset_ready_ce0 got=%b exp=0", BLK_READY); end
        CE = 1; RST = 0; #1;
        checks++; if (STATE_CLEAR !== 1'b1) begin failures++; $display("FAIL reset_clear_after_fall got=%b exp=1", STATE_CLEAR); end
        step();
        checks++; if (STATE_CLEAR !== 1'b0) begin failures++; $display("FAIL reset_clear_end got=%b exp=0", STATE_CLEAR); end
    endtask

    task automatic test_single_block();
        BLK_VALID = 1; BLK_LAST = 1; #1;
        checks++; if (BLK_READY !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", BLK_READY); end
        step();
        BLK_VALID = 0; #1;
        checks++; if (STATE_LOAD !== 1'b1 || ROUND_EN !== 1'b0) begin failures++; $display("FAIL single_load got=%b%b exp=10", STATE_LOAD, ROUND_EN); end
        step();
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (ROUND_EN !== 1'b1 || ROUND_IDX !== 5'(k * STEP) || ROUND_IDX_B !== ((STEP == 2) ? 5'(k * STEP + 1) : 5'd0) || DIGEST_VALID !== 1'b0) begin
                failures++;
                $display("FAIL single_round k=%0d got en=%b idx=%0d idxb=%0d dv=%b exp idx=%0d", k, ROUND_EN, ROUND_IDX, ROUND_IDX_B, DIGEST_VALID, k * STEP);
            end
            step();
        end
        checks++; if (DIGEST_VALID !== 1'b1 || ROUND_EN !== 1'b0 || ROUND_IDX !== 5'd0) begin failures++; $display("FAIL single_digest got dv=%b en=%b idx=%0d exp 1/0/0", DIGEST_VALID, ROUND_EN, ROUND_IDX); end
        step();
        checks++; if (DIGEST_VALID !== 1'b1) begin failures++; $display("FAIL single_digest_hold got=%b exp=1", DIGEST_VALID); end
        DIGEST_ACK = 1; #1;
        checks++; if (STATE_CLEAR !== 1'b1) begin failures++; $display("FAIL single_ack_clear got=%b exp=1", STATE_CLEAR); end
        step();
        DIGEST_ACK = 0; #1;
        checks++; if (DIGEST_VALID !== 1'b0 || STATE_CLEAR !== 1'b0 || WAIT_FOR_NEW_MESSAGE !== 1'b1 || BLK_READY !== 1'b1) begin
            failures++; $display("FAIL single_done got dv=%b clr=%b wait=%b rdy=%b exp 0/0/1/1", DIGEST_VALID, STATE_CLEAR, WAIT_FOR_NEW_MESSAGE, BLK_READY);
        end
    endtask

    task automatic test_two_blocks();
        bit saw_clear = 0;
        bit saw_dv = 0;
        BLK_VALID = 1; BLK_LAST = 0; #1;
        step();
        BLK_VALID = 0;
        for (int c = 0; c < NR + 1; c++) begin
            #1; saw_clear |= STATE_CLEAR; saw_dv |= DIGEST_VALID;
            step();
        end
        checks++; if (WAIT_FOR_NEW_MESSAGE !== 1'b0 || BLK_READY !== 1'b1 || DIGEST_VALID !== 1'b0 || STATE_CLEAR !== 1'b0) begin
            failures++; $display("FAIL two_mid got wait=%b rdy=%b dv=%b clr=%b exp 0/1/0/0", WAIT_FOR_NEW_MESSAGE, BLK_READY, DIGEST_VALID, STATE_CLEAR);
        end
        BLK_VALID = 1; BLK_LAST = 1; #1;
        step();
        BLK_VALID = 0;
        for (int c = 0; c < NR + 1; c++) begin
            #1; saw_clear |= STATE_CLEAR; saw_dv |= DIGEST_VALID;
            step();
        end
        checks++; if (saw_clear !== 1'b0 || saw_dv !== 1'b0) begin failures++; $display("FAIL two_early got clear=%b dv=%b exp 0/0", saw_clear, saw_dv); end
        checks++; if (DIGEST_VALID !== 1'b1) begin failures++; $display("FAIL two_digest got=%b exp=1", DIGEST_VALID); end
        DIGEST_ACK = 1; #1; step(); DIGEST_ACK = 0; #1;
    endtask

    task automatic test_ce_stall();
        int lat = 0;
        BLK_VALID = 1; BLK_LAST = 1; #1;
        step(); lat++;
        BLK_VALID = 0;
        step(); lat++;
        for (int k = 0; k < 10 / STEP; k++) begin step(); lat++; end
        checks++; if (ROUND_IDX !== 5'd10) begin failures++; $display("FAIL stall_pre got=%0d exp=10", ROUND_IDX); end
        CE = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ROUND_EN !== 1'b0 || ROUND_IDX !== 5'd10 || BLK_READY !== 1'b0) begin failures++; $display("FAIL stall_hold c=%0d got en=%b idx=%0d exp 0/10", c, ROUND_EN, ROUND_IDX); end
            step(); lat++;
        end
        CE = 1; #1;
        checks++; if (ROUND_EN !== 1'b1 || ROUND_IDX !== 5'd10) begin failures++; $display("FAIL stall_resume got en=%b idx=%0d exp 1/10", ROUND_EN, ROUND_IDX); end
        step(); lat++;
        checks++; if (ROUND_IDX !== 5'(10 + STEP)) begin failures++; $display("FAIL stall_next got=%0d exp=%0d", ROUND_IDX, 10 + STEP); end
        while (DIGEST_VALID !== 1'b1 && lat < 200) begin step(); lat++; end
        checks++; if (lat != NR + 2 + 3) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", lat, NR + 5); end
        DIGEST_ACK = 1; #1; step(); DIGEST_ACK = 0; #1;
    endtask

    task automatic test_reset_mid_round();
        BLK_VALID = 1; BLK_LAST = 1; #1;
        step();
        BLK_VALID = 0;
        step();
        for (int k = 0; k < 15 / STEP; k++) step();
        checks++; if (ROUND_IDX !== 5'((15 / STEP) * STEP)) begin failures++; $display("FAIL rstmid_pre got=%0d exp=%0d", ROUND_IDX, (15 / STEP) * STEP); end
        RST = 1; #1;
        step();
        checks++; if (ROUND_EN !== 1'b0 || STATE_CLEAR !== 1'b1 || WAIT_FOR_NEW_MESSAGE !== 1'b1 || ROUND_IDX !== 5'd0 || BLK_READY !== 1'b1) begin
            failures++; $display("FAIL rstmid_idle got en=%b clr=%b wait=%b idx=%0d rdy=%b exp 0/1/1/0/1", ROUND_EN, STATE_CLEAR, WAIT_FOR_NEW_MESSAGE, ROUND_IDX, BLK_READY);
        end
        RST = 0; BLK_VALID = 1; BLK_LAST = 1; #1;
        checks++; if (STATE_CLEAR !== 1'b1 || BLK_READY !== 1'b1) begin failures++; $display("FAIL rstmid_release got clr=%b rdy=%b exp 1/1", STATE_CLEAR, BLK_READY); end
        step();
        BLK_VALID = 0; #1;
        checks++; if (STATE_LOAD !== 1'b1 || STATE_CLEAR !== 1'b0) begin failures++; $display("FAIL rstmid_load got ld=%b clr=%b exp 1/0", STATE_LOAD, STATE_CLEAR); end
        for (int c = 0; c < NR + 1; c++) step();
        checks++; if (DIGEST_VALID !== 1'b1) begin failures++; $display("FAIL rstmid_digest got=%b exp=1", DIGEST_VALID); end
        DIGEST_ACK = 1; #1; step(); DIGEST_ACK = 0; #1;
    endtask

    task automatic test_ack_hold();
        BLK_VALID = 1; BLK_LAST = 1; #1;
        step();
        BLK_VALID = 0;
        for (int c = 0; c < NR + 1; c++) step();
        BLK_VALID = 1;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (DIGEST_VALID !== 1'b1 || BLK_READY !== 1'b0 || STATE_LOAD !== 1'b0) begin
                failures++; $display("FAIL ackhold c=%0d got dv=%b rdy=%b ld=%b exp 1/0/0", c, DIGEST_VALID, BLK_READY, STATE_LOAD);
            end
            step();
        end
        BLK_VALID = 0; DIGEST_ACK = 1; #1;
        checks++; if (STATE_CLEAR !== 1'b1) begin failures++; $display("FAIL ackhold_clear got=%b exp=1", STATE_CLEAR); end
        step();
        DIGEST_ACK = 0; #1;
    endtask

    // Reference: a message walks a linear timeline 0=idle, 1=absorb, 2..NR+1=rounds, NR+2=digest,
    // moving one position per enabled cycle (idle waits for a block, digest waits for an ack).
    task automatic test_random();
        int  pos = 0;
        bit  m_last = 0, m_done = 1, prev_rst = 0;
        bit  e_rdy, e_ld, e_en, e_dv, e_wait, e_clr;
        int  e_idx, e_idxb;
        for (int i = 0; i < 3000; i++) begin
            RST        = (i == 0) || ($urandom_range(0, 199) == 0);
            CE         = ($urandom_range(0, 7) != 0);
            BLK_VALID  = ($urandom_range(0, 2) == 0);
            BLK_LAST   = $urandom_range(0, 1) == 1;
            DIGEST_ACK = ($urandom_range(0, 3) == 0);
            #1;
            if (i > 0) begin
                e_rdy  = (pos == 0) && CE;
                e_ld   = (pos == 1) && CE;
                e_en   = (pos >= 2) && (pos <= NR + 1) && CE;
                e_idx  = ((pos >= 2) && (pos <= NR + 1)) ? (pos - 2) * STEP : 0;
                e_idxb = ((pos >= 2) && (pos <= NR + 1) && STEP == 2) ? e_idx + 1 : 0;
                e_dv   = (pos == NR + 2);
                e_wait = (pos == 0) && m_done;
                e_clr  = RST || prev_rst || ((pos == NR + 2) && DIGEST_ACK && CE);
                checks++;
                if ({BLK_READY, STATE_LOAD, ROUND_EN, DIGEST_VALID, WAIT_FOR_NEW_MESSAGE, STATE_CLEAR} !== {e_rdy, e_ld, e_en, e_dv, e_wait, e_clr}
                    || ROUND_IDX !== 5'(e_idx) || ROUND_IDX_B !== 5'(e_idxb)) begin
                    failures++;
                    $display("FAIL random i=%0d got rdy/ld/en/dv/wait/clr=%b%b%b%b%b%b idx=%0d/%0d exp %b%b%b%b%b%b idx=%0d/%0d",
                             i, BLK_READY, STATE_LOAD, ROUND_EN, DIGEST_VALID, WAIT_FOR_NEW_MESSAGE, STATE_CLEAR, ROUND_IDX, ROUND_IDX_B,
                             e_rdy, e_ld, e_en, e_dv, e_wait, e_clr, e_idx, e_idxb);
                end
            end
            if (RST) begin
                pos = 0; m_last = 0; m_done = 1;
            end else if (CE) begin
                if (pos == 0) begin
                    if (BLK_VALID) begin m_last = BLK_LAST; m_done = 0; pos = 1; end
                end else if (pos == NR + 1) begin
                    pos = m_last ? NR + 2 : 0;
                end else if (pos == NR + 2) begin
                    if (DIGEST_ACK) begin pos = 0; m_done = 1; m_last = 0; end
                end else begin
                    pos++;
                end
            end
            prev_rst = RST;
            step();
        end
        RST = 0; CE = 1; BLK_VALID = 0; DIGEST_ACK = 0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_two_blocks();
        test_ce_stall();
        test_reset_mid_round();
        test_ack_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
